branch_cond_unit: RTL
=====================

// Module: branch_cond_unit
// PURPOSE
//  Consumer of the ALU flag vector: takes {V,C,N,Z} from a SUB compare plus branch info,
//  resolves RISC-V B-type conditions and jumps, and computes the target.
//  Produces a registered result under valid/ready and a one-cycle redirect to fetch.
//  Squashes a fixed number of wrong-path ops after every taken branch or jump.
// PARAMETERS
//  BITS    64  datapath width of pc, imm and target
//  SQUASH  2   ops after a taken branch/jump that are consumed and dropped (0 = none)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous reset, active-low
//  in_valid     in   1       input op valid
//  in_ready     out  1       unit accepts op this cycle
//  is_branch    in   1       op is a conditional branch
//  is_jump      in   1       op is JAL/JALR; always taken; overrides is_branch
//  funct3       in   [0:2]   branch condition code
//  ALUFlags     in   [0:3]   {V,C,N,Z} of SrcA-SrcB; bit 0 = V, bit 3 = Z
//  pc           in   [0:BITS-1]  op address
//  imm          in   [0:BITS-1]  sign-extended offset
//  out_valid    out  1       result valid
//  out_ready    in   1       downstream accepts result
//  out_taken    out  1       branch/jump taken
//  out_target   out  [0:BITS-1]  pc+imm, modulo 2^BITS
//  out_illegal  out  1       is_branch with reserved funct3 (010, 011)
//  redirect     out  1       one-cycle pulse: fetch must go to redirect_pc
//  redirect_pc  out  [0:BITS-1]  equals out_target while redirect=1
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid, out_taken, out_illegal and redirect = 0;
//   out_target and redirect_pc = 0; squash counter = 0; FSM = RUN.
//  Handshake: in_ready = ~out_valid | out_ready. Op accepted when in_valid & in_ready.
//   out_valid and all out_* hold stable until out_valid & out_ready.
//  Latency: one cycle. A RUN-state op accepted at edge k is visible on out_* after edge k.
//  Conditions (used when is_branch=1 and is_jump=0):
//   000 BEQ Z | 001 BNE ~Z | 100 BLT N^V | 101 BGE ~(N^V) | 110 BLTU ~C | 111 BGEU C.
//   010/011 -> out_taken=0, out_illegal=1.
//  Other ops: is_jump=1 -> taken=1, illegal=0. is_branch=is_jump=0 -> taken=0, illegal=0
//   (pass-through op).
//  Target: out_target = pc + imm, truncated to BITS; computed for every op.
//  redirect: high exactly one cycle, on the cycle after accepting a taken op. This is the
//   same cycle out_valid rises. It is not re-asserted while out_valid stalls.
//  FSM:
//   RUN: accept and evaluate. If a taken op is accepted and SQUASH>0, go to SQUASHING
//    with cnt=SQUASH.
//   SQUASHING: in_ready follows the same rule. Each accepted op is dropped: no out_valid,
//    no redirect, cnt decrements. At cnt 1->0, go to RUN.
//    Cycles with in_valid=0 do not decrement.
//  Simultaneous: an accept and an out handshake in the same cycle load the new op (no bubble).
//   The last squashed op and a new valid op never overlap; the next op is evaluated
//   normally after the return to RUN.
//  Reset mid-squash or mid-stall: everything returns to the reset values. The held
//   result is discarded.
//  Flags are sampled only on accept; flags outside the accept cycle are ignored.
// TESTING
//  1 BEQ, flags 0001, pc=0x100, imm=0x20 -> next cycle out_valid=1, taken=1,
//    target=0x120, redirect pulse=1.
//  2 BLT/BGE/BLTU/BGEU with flags 1000, 0010, 0100, 0000 -> taken exactly per the
//    table (1000 -> BLT taken).
//  3 Taken JAL with SQUASH=2 -> next 2 accepted ops give no out_valid; third op
//    evaluated normally.
//  4 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* stable,
//    redirect high only the first cycle.
//  5 funct3=010 branch -> out_illegal=1, taken=0. pc=0xFFFF_FFFF_FFFF_FFF0, imm=0x20
//    -> target=0x10.
//  6 rst_n low during SQUASHING, cnt=1 -> all outputs 0; first op after release is not
//    squashed.

Source files
------------

// File: rtl/branch_cond_unit_if.sv
// Op/result bundle between the issue stage and the branch condition unit.
// The unit attaches to the slave modport; the issuing side uses master.
interface branch_cond_unit_if #(
    parameter int BITS = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            is_branch;
    logic            is_jump;
    logic [0:2]      funct3;
    logic [0:3]      ALUFlags;
    logic [0:BITS-1] pc;
    logic [0:BITS-1] imm;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [0:BITS-1] out_target;
    logic            out_illegal;
    logic            redirect;
    logic [0:BITS-1] redirect_pc;

    modport master (
        output in_valid, is_branch, is_jump, funct3, ALUFlags, pc, imm, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_illegal, redirect, redirect_pc
    );

    modport slave (
        input  in_valid, is_branch, is_jump, funct3, ALUFlags, pc, imm, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_illegal, redirect, redirect_pc
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Resolves RISC-V branch/jump conditions from {V,C,N,Z}, registers the result,
// pulses a fetch redirect and drops a fixed number of wrong-path ops afterwards.
module branch_cond_unit #(
    parameter int BITS   = 64,
    parameter int SQUASH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_cond_unit_if.slave  bus
);
    localparam int CW = (SQUASH > 1) ? $clog2(SQUASH + 1) : 1;

    typedef enum logic {RUN, SQUASHING} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;
    logic            redirect_q, redirect_d;
    logic [BITS-1:0] target_q, target_d;
    logic [BITS-1:0] rpc_q, rpc_d;

    logic            in_ready, accept;
    logic            cond_taken, cond_illegal;
    logic            flag_v, flag_c, flag_n, flag_z;
    logic [BITS-1:0] sum;

    assign {flag_v, flag_c, flag_n, flag_z} = bus.ALUFlags;
    assign sum      = bus.pc + bus.imm;
    assign in_ready = ~out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;

    // Jumps win over the branch bit; reserved funct3 never takes.
    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        if (bus.is_jump) begin
            cond_taken = 1'b1;
        end else if (bus.is_branch) begin
            case (bus.funct3)
                3'b000:  cond_taken = flag_z;
                3'b001:  cond_taken = ~flag_z;
                3'b100:  cond_taken = flag_n ^ flag_v;
                3'b101:  cond_taken = ~(flag_n ^ flag_v);
                3'b110:  cond_taken = ~flag_c;
                3'b111:  cond_taken = flag_c;
                default: cond_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        taken_d     = taken_q;
        illegal_d   = illegal_q;
        target_d    = target_q;
        rpc_d       = rpc_q;
        redirect_d  = 1'b0;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (accept) begin
            if (state_q == RUN) begin
                out_valid_d = 1'b1;
                taken_d     = cond_taken;
                illegal_d   = cond_illegal;
                target_d    = sum;
                redirect_d  = cond_taken;
                if (cond_taken) rpc_d = sum;
                if (cond_taken && SQUASH > 0) begin
                    state_d = SQUASHING;
                    cnt_d   = CW'(SQUASH);
                end
            end else begin
                // Wrong-path op: consumed, never reported.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            redirect_q  <= 1'b0;
            target_q    <= '0;
            rpc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            taken_q     <= taken_d;
            illegal_q   <= illegal_d;
            redirect_q  <= redirect_d;
            target_q    <= target_d;
            rpc_q       <= rpc_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_taken   = taken_q;
    assign bus.out_illegal = illegal_q;
    assign bus.out_target  = target_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = rpc_q;
endmodule
